// File: rtl/mem_access_unit.sv
// Memory access unit: serialises fetch / load / store requests from a multicycle control FSM onto a single memory port.
// Latency: request cycle -> BUSY (>=1 cycle, until mem_ready or TIMEOUT wait cycles) -> one DONE cycle; minimum 2 cycles to DONE.
// Backpressure: Stall holds the control FSM from the request cycle through BUSY; DONE releases it for exactly one cycle.
module mem_access_unit #(
   parameter int TIMEOUT = 255,
   parameter int AW      = 16
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          IRWrite,
   input  logic          MemR,
   input  logic          MemW,
   input  logic          IoD,
   input  logic [AW-1:0] PC,
   input  logic [AW-1:0] ALUOut,
   input  logic [15:0]   WriteData,
   input  logic [15:0]   mem_rdata,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [15:0]   IR,
   output logic [15:0]   MDR,
   output logic [6:0]    ctrl_field,
   output logic          Stall,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Last wait-counter value before the abort: the TIMEOUT-th idle BUSY cycle ends the access.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   ir_q, ir_d;
   logic [15:0]   mdr_q, mdr_d;
   logic          we_q, we_d;
   logic          fetch_q, fetch_d;
   logic          err_q, err_d;
   logic [7:0]    wait_q, wait_d;

   logic req_any;
   logic req_multi;
   logic timeout_hit;

   assign req_any     = IRWrite | MemR | MemW;
   assign req_multi   = (IRWrite & MemR) | (IRWrite & MemW) | (MemR & MemW);
   assign timeout_hit = (state_q == S_BUSY) && !mem_ready && (wait_q == WAIT_LAST);

   // State register.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: IDLE waits for a request, BUSY for completion or abort, DONE always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_any) state_d = S_BUSY;
         S_BUSY:  if (mem_ready || timeout_hit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: Stall covers the request cycle and BUSY; mem_req is high only in BUSY.
   always_comb begin
      Stall   = 1'b0;
      mem_req = 1'b0;
      case (state_q)
         S_IDLE: Stall = req_any;
         S_BUSY: begin
            Stall   = 1'b1;
            mem_req = 1'b1;
         end
         default: begin
            Stall   = 1'b0;
            mem_req = 1'b0;
         end
      endcase
   end

   // Datapath next state: capture on request, load IR/MDR on read completion, count waits, raise err.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      fetch_d = fetch_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;
      wait_d  = wait_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               // Only data accesses honour IoD; a lone fetch always uses PC.
               addr_d  = ((MemW | MemR) && IoD) ? ALUOut : PC;
               wdata_d = WriteData;
               we_d    = MemW;
               fetch_d = !MemW && !MemR;
               wait_d  = 8'd0;
               if (req_multi) err_d = 1'b1;
            end
         end
         S_BUSY: begin
            if (mem_ready) begin
               if (!we_q) begin
                  if (fetch_q) ir_d  = mem_rdata;
                  else         mdr_d = mem_rdata;
               end
               we_d = 1'b0;
            end else begin
               wait_d = wait_q + 8'd1;
               if (timeout_hit) begin
                  err_d = 1'b1;
                  we_d  = 1'b0;
               end
            end
         end
         default: begin
            wait_d = wait_q;
         end
      endcase
   end

   // Datapath registers; reset discards any pending access.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         addr_q  <= '0;
         wdata_q <= 16'd0;
         we_q    <= 1'b0;
         fetch_q <= 1'b0;
         ir_q    <= 16'd0;
         mdr_q   <= 16'd0;
         wait_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         fetch_q <= fetch_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_we     = we_q;
   assign IR         = ir_q;
   assign MDR        = mdr_q;
   assign err        = err_q;
   assign ctrl_field = {ir_q[15:12], ir_q[2:0]};

endmodule
